ram_readback_streamer: RTL and testbench
========================================

// Module: ram_readback_streamer
// PURPOSE
//  Reader counterpart to the UART-fed instruction-RAM write path: on a start request, reads
//  instruction RAM from address 0 to MAX_ADDRESS and hands each word to the UART transmitter,
//  one word per TX handshake. Sits between instruction RAM read port and uart_tx; used for
//  program readback/verification over the serial link.
// PARAMETERS
//  N            2   RAM address width
//  MAX_ADDRESS  3   last address streamed (inclusive); must be <= 2**N-1
//  DATA_W       8   RAM word / TX byte width
//  RD_LATENCY   1   cycles from ram_rd_en to valid ram_data (legal: 1 or 2)
// PORTS
//  clk       in   1       system clock, all state on posedge
//  rst       in   1       asynchronous, active-high reset
//  start     in   1       level request; internally rising-edge detected (synchronised, 2 flops)
//  ram_addr  out  N       read address to instruction RAM
//  ram_rd_en out  1       one-cycle read strobe
//  ram_data  in   DATA_W  RAM read data, valid RD_LATENCY cycles after ram_rd_en
//  tx_data   out  DATA_W  byte to uart_tx, held stable from tx_start until word done
//  tx_start  out  1       one-cycle pulse requesting uart_tx to send tx_data
//  tx_busy   in   1       uart_tx busy flag (high while shifting a frame)
//  busy      out  1       high whenever FSM is not IDLE
//  done      out  1       one-cycle pulse after last word's frame completes
// BEHAVIOUR
//  Reset (async assert, any state): FSM->IDLE, addr counter=0, ram_addr=0, tx_data=0,
//   ram_rd_en=0, tx_start=0, busy=0, done=0, edge-detect flops=0. Deassert: resume clean in IDLE.
//  States: IDLE, READ, WAIT_DATA, SEND, WAIT_ACCEPT, WAIT_FRAME, DONE.
//   IDLE:        start rising edge -> addr=0, READ. Edges while not IDLE are ignored (not queued).
//   READ:        ram_rd_en=1 for 1 cycle with ram_addr=addr -> WAIT_DATA.
//   WAIT_DATA:   count RD_LATENCY cycles; on last, register ram_data into tx_data -> SEND.
//   SEND:        tx_start=1 for exactly 1 cycle -> WAIT_ACCEPT.
//   WAIT_ACCEPT: wait tx_busy=1 -> WAIT_FRAME (if tx_busy already high, next cycle moves on).
//   WAIT_FRAME:  wait tx_busy=0; then if addr==MAX_ADDRESS -> DONE, else addr<=addr+1 -> READ.
//   DONE:        done=1 for 1 cycle; addr<=0 -> IDLE.
//  Counter: N-bit, increments only in WAIT_FRAME exit; compare against MAX_ADDRESS before
//   increment, so no wrap occurs; MAX_ADDRESS=2**N-1 still terminates correctly.
//  ram_addr is registered and stable from READ through WAIT_DATA.
//  tx_data changes only in WAIT_DATA capture; stable across SEND..WAIT_FRAME.
//  Per-word minimum latency (tx_busy responds in 1 cycle): READ(1)+WAIT_DATA(RD_LATENCY)+SEND(1)
//   + accept + frame time. Frame start of word k+1 never precedes tx_busy falling for word k.
//  MAX_ADDRESS=0: exactly one word streamed, then done.
//  Reset mid-transfer: abort immediately; no further tx_start; partially sent frame is uart_tx's concern.
//  start held high continuously: exactly one stream per rising edge.
//  No hang protection: tx_busy stuck low in WAIT_ACCEPT stalls until rst (documented limitation).
// STRUCTURE
//  Shared package uart_pkg: typedef enum logic [2:0] streamer_state_t {IDLE..DONE}.
//  One sub-module: edge_detect_rise (2-flop sync + prev-flop, async rst, outputs 1-cycle pulse),
//   reusable by the write-side counter. FSM, counter, latency counter, output regs stay in this module.
// TESTING (N=2, MAX_ADDRESS=3, RAM = A1,B2,C3,D4; TX model: busy 1 cycle after tx_start, 10 cycles)
//  1 Full stream: pulse start -> tx_data sequence A1,B2,C3,D4, 4 tx_start pulses, addrs 0..3, one done.
//  2 Latency: RD_LATENCY=2 -> tx_data captured exactly 2 cycles after each ram_rd_en; same byte sequence.
//  3 Back-pressure: TX model busy=40 cycles -> no tx_start while tx_busy=1; still A1..D4 in order.
//  4 Start abuse: start held high 200 cycles and re-pulsed mid-stream -> exactly 4 words, 1 done.
//  5 Reset mid-op: assert rst during WAIT_FRAME of word B2 -> all outputs 0 same cycle (async);
//    new start -> stream restarts at A1.
//  6 Edge config: MAX_ADDRESS=0 -> single A1 then done; MAX_ADDRESS=3,N=2 -> no wrap, no 5th word.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the serial program-load / readback path.
// Holds the readback streamer state encoding so checkers and the bench agree on it.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ        = 3'd1,
        WAIT_DATA   = 3'd2,
        SEND        = 3'd3,
        WAIT_ACCEPT = 3'd4,
        WAIT_FRAME  = 3'd5,
        DONE        = 3'd6
    } streamer_state_t;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector for an asynchronous level input: two synchroniser flops
// followed by a previous-value flop; emits a single-cycle pulse per rising edge.
module edge_detect_rise (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_pulse
);

    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_level};
            r_prev <= r_sync[1];
        end
    end

    assign o_pulse = r_sync[1] & ~r_prev;

endmodule

// File: rtl/ram_readback_streamer.sv
// Streams instruction RAM words 0..MAX_ADDRESS to uart_tx, one word per TX handshake.
// Handshake: tx_start is a 1-cycle request; the word is accepted once tx_busy rises and finished once it falls.
module ram_readback_streamer
    import uart_pkg::*;
#(
    parameter int N           = 2,
    parameter int MAX_ADDRESS = 3,
    parameter int DATA_W      = 8,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N-1:0]      ram_addr,
    output logic              ram_rd_en,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output streamer_state_t   dbg_state
);

    localparam logic [N-1:0] LAST_ADDR = N'(MAX_ADDRESS);
    localparam logic [1:0]   LAT_LAST  = 2'(RD_LATENCY - 1);

    streamer_state_t   r_state;
    streamer_state_t   w_next;
    logic [N-1:0]      r_addr;
    logic [1:0]        r_lat_cnt;
    logic [DATA_W-1:0] r_tx_data;
    logic              w_start_pulse;
    logic              w_lat_done;
    logic              w_addr_last;

    edge_detect_rise u_start_edge (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_level (start),
        .o_pulse (w_start_pulse)
    );

    assign w_lat_done  = (r_lat_cnt == LAT_LAST);
    // Compared before incrementing, so MAX_ADDRESS = 2**N-1 never wraps.
    assign w_addr_last = (r_addr == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:        if (w_start_pulse) w_next = READ;
            READ:        w_next = WAIT_DATA;
            WAIT_DATA:   if (w_lat_done) w_next = SEND;
            SEND:        w_next = WAIT_ACCEPT;
            WAIT_ACCEPT: if (tx_busy) w_next = WAIT_FRAME;
            WAIT_FRAME:  if (!tx_busy) w_next = w_addr_last ? DONE : READ;
            DONE:        w_next = IDLE;
            default:     w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_lat_cnt <= 2'd0;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_pulse) r_addr <= '0;
                end
                READ: begin
                    r_lat_cnt <= 2'd0;
                end
                WAIT_DATA: begin
                    r_lat_cnt <= r_lat_cnt + 2'd1;
                    if (w_lat_done) r_tx_data <= ram_data;
                end
                WAIT_FRAME: begin
                    if (!tx_busy && !w_addr_last) r_addr <= r_addr + N'(1);
                end
                DONE: begin
                    r_addr <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so an async reset clears them at once.
    assign ram_addr  = r_addr;
    assign ram_rd_en = (r_state == READ);
    assign tx_data   = r_tx_data;
    assign tx_start  = (r_state == SEND);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ram_readback_streamer.sv
// Bench for ram_readback_streamer: three instances (base, RD_LATENCY=2, MAX_ADDRESS=0)
// share clock, reset and start; each has its own RAM model and uart_tx busy model.
module tb_ram_readback_streamer;
    import uart_pkg::*;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;

    logic [2:0]      rd_en;
    logic [2:0]      tx_start;
    logic [2:0]      tx_busy;
    logic [2:0]      busy;
    logic [2:0]      done;
    logic [1:0]      ram_addr [3];
    logic [7:0]      ram_data [3];
    logic [7:0]      tx_data  [3];
    streamer_state_t dbg      [3];

    logic [7:0] mem [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] d1  [3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] d2  [3] = '{8'h00, 8'h00, 8'h00};
    int busy_cnt    [3] = '{0, 0, 0};

    int checks   = 0;
    int failures = 0;
    int tx_len   = 10;
    int cyc      = 0;
    int done_cnt [3] = '{0, 0, 0};
    int lat_err  [3] = '{0, 0, 0};
    int bp_err   [3] = '{0, 0, 0};
    int stab_err [3] = '{0, 0, 0};
    int last_rd  [3] = '{0, 0, 0};
    logic [7:0] last_sent [3] = '{8'h00, 8'h00, 8'h00};

    logic [9:0] got_q  [$];
    logic [3:0] addr_q [$];
    int md;
    int ma;
    int bd [3];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    ram_readback_streamer #(.N(2), .MAX_ADDRESS(3), .DATA_W(8), .RD_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst), .start(start),
        .ram_addr(ram_addr[0]), .ram_rd_en(rd_en[0]), .ram_data(ram_data[0]),
        .tx_data(tx_data[0]), .tx_start(tx_start[0]), .tx_busy(tx_busy[0]),
        .busy(busy[0]), .done(done[0]), .dbg_state(dbg[0])
    );

    ram_readback_streamer #(.N(2), .MAX_ADDRESS(3), .DATA_W(8), .RD_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .ram_addr(ram_addr[1]), .ram_rd_en(rd_en[1]), .ram_data(ram_data[1]),
        .tx_data(tx_data[1]), .tx_start(tx_start[1]), .tx_busy(tx_busy[1]),
        .busy(busy[1]), .done(done[1]), .dbg_state(dbg[1])
    );

    ram_readback_streamer #(.N(2), .MAX_ADDRESS(0), .DATA_W(8), .RD_LATENCY(1)) dut2 (
        .clk(clk), .rst(rst), .start(start),
        .ram_addr(ram_addr[2]), .ram_rd_en(rd_en[2]), .ram_data(ram_data[2]),
        .tx_data(tx_data[2]), .tx_start(tx_start[2]), .tx_busy(tx_busy[2]),
        .busy(busy[2]), .done(done[2]), .dbg_state(dbg[2])
    );

    // RAM data is only valid in exactly the cycle RD_LATENCY after the strobe.
    assign ram_data[0] = d1[0];
    assign ram_data[1] = d2[1];
    assign ram_data[2] = d1[2];
    assign tx_busy[0]  = (busy_cnt[0] != 0);
    assign tx_busy[1]  = (busy_cnt[1] != 0);
    assign tx_busy[2]  = (busy_cnt[2] != 0);

    function automatic int lat_of(input int inst);
        return (inst == 1) ? 2 : 1;
    endfunction

    // ---------------- RAM + uart_tx models ----------------
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            d1[i] <= rd_en[i] ? mem[ram_addr[i]] : 8'h00;
            d2[i] <= d1[i];
            if (rst)                  busy_cnt[i] <= 0;
            else if (tx_start[i])     busy_cnt[i] <= tx_len;
            else if (busy_cnt[i] != 0) busy_cnt[i] <= busy_cnt[i] - 1;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_en[i]) begin
                addr_q.push_back({2'(i), ram_addr[i]});
                last_rd[i] = cyc;
            end
            if (tx_start[i]) begin
                got_q.push_back({2'(i), tx_data[i]});
                last_sent[i] = tx_data[i];
                if (cyc - last_rd[i] != lat_of(i) + 1) lat_err[i]++;
                if (tx_busy[i]) bp_err[i]++;
            end else if (tx_busy[i] && tx_data[i] != last_sent[i]) begin
                stab_err[i]++;
            end
            if (done[i]) done_cnt[i]++;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_inst(input int inst, input int from);
        int n = 0;
        for (int j = from; j < got_q.size(); j++)
            if (got_q[j][9:8] == 2'(inst)) n++;
        return n;
    endfunction

    task automatic check_stream(input int inst, input int nwords, input string tag);
        logic [7:0] exp_q [$];
        logic [1:0] exp_a [$];
        int n = 0;
        for (int k = 0; k < nwords; k++) begin
            exp_q.push_back(mem[k]);
            exp_a.push_back(2'(k));
        end
        for (int j = md; j < got_q.size(); j++) begin
            if (got_q[j][9:8] == 2'(inst)) begin
                n++;
                if (exp_q.size() != 0) check_eq({tag, "_byte"}, got_q[j][7:0], exp_q.pop_front());
            end
        end
        check_eq({tag, "_nwords"}, n, nwords);
        n = 0;
        for (int j = ma; j < addr_q.size(); j++) begin
            if (addr_q[j][3:2] == 2'(inst)) begin
                n++;
                if (exp_a.size() != 0) check_eq({tag, "_addr"}, addr_q[j][1:0], exp_a.pop_front());
            end
        end
        check_eq({tag, "_nreads"}, n, nwords);
        check_eq({tag, "_done_cnt"}, done_cnt[inst] - bd[inst], 1);
    endtask

    task automatic check_health(input int inst, input string tag);
        check_eq({tag, "_latency"}, lat_err[inst], 0);
        check_eq({tag, "_backpressure"}, bp_err[inst], 0);
        check_eq({tag, "_tx_stable"}, stab_err[inst], 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic mark();
        md = got_q.size();
        ma = addr_q.size();
        for (int i = 0; i < 3; i++) bd[i] = done_cnt[i];
    endtask

    task automatic pulse_start(input int len);
        @(negedge clk);
        start = 1'b1;
        repeat (len) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int budget, input string tag);
        int n = 0;
        while (done_cnt[inst] <= bd[inst] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done_seen"}, (done_cnt[inst] > bd[inst]) ? 1 : 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        #1;
        check_eq("reset_outs0", {18'd0, ram_addr[0], rd_en[0], tx_data[0], tx_start[0], busy[0], done[0]}, 0);
        check_eq("reset_outs1", {18'd0, ram_addr[1], rd_en[1], tx_data[1], tx_start[1], busy[1], done[1]}, 0);
        check_eq("reset_state", dbg[0], IDLE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Full stream on all three configs (base, latency 2, single word)
        tx_len = 10;
        mark();
        pulse_start(2);
        wait_done(0, 400, "t1_base");
        wait_done(1, 400, "t2_lat2");
        wait_done(2, 400, "t6_max0");
        repeat (60) @(negedge clk);
        check_stream(0, 4, "t1_base");
        check_stream(1, 4, "t2_lat2");
        check_stream(2, 1, "t6_max0");
        check_eq("t6_idle_after", {busy[0], busy[1], busy[2]}, 3'b000);
        check_health(0, "t1_base");
        check_health(1, "t2_lat2");
        check_health(2, "t6_max0");

        // Back-pressure: long frames
        tx_len = 40;
        mark();
        pulse_start(2);
        wait_done(0, 600, "t3_bp");
        repeat (20) @(negedge clk);
        check_stream(0, 4, "t3_bp");
        check_health(0, "t3_bp");

        // Start held high for 200 cycles
        tx_len = 10;
        repeat (5) @(negedge clk);
        mark();
        @(negedge clk);
        start = 1'b1;
        repeat (200) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check_stream(0, 4, "t4_held");

        // Re-pulse while a stream is in flight
        mark();
        pulse_start(2);
        repeat (20) @(negedge clk);
        pulse_start(3);
        wait_done(0, 400, "t4_repulse");
        repeat (60) @(negedge clk);
        check_stream(0, 4, "t4_repulse");
        check_health(0, "t4");

        // Async reset while word B2's frame is in flight
        mark();
        pulse_start(2);
        n = 0;
        while (!(count_inst(0, md) == 2 && dbg[0] == WAIT_FRAME) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("t5_reach_b2_frame", count_inst(0, md), 2);
        check_eq("t5_pre_reset_byte", tx_data[0], 8'hB2);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_async_outs", {18'd0, ram_addr[0], rd_en[0], tx_data[0], tx_start[0], busy[0], done[0]}, 0);
        check_eq("t5_async_state", dbg[0], IDLE);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("t5_no_tx_after_rst", count_inst(0, md), 2);
        mark();
        pulse_start(2);
        wait_done(0, 400, "t5_restart");
        repeat (40) @(negedge clk);
        check_stream(0, 4, "t5_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
